// File: rtl/st7789_pkg.sv
// Shared ST7789 command codes and the receive-side command decoder states.
package st7789_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_NORON   = 8'h13;
    localparam logic [7:0] CMD_INVON   = 8'h21;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_RASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] CMD_MADCTL  = 8'h36;
    localparam logic [7:0] CMD_COLMOD  = 8'h3A;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CASET0, S_CASET1, S_CASET2, S_CASET3,
        S_RASET0, S_RASET1, S_RASET2, S_RASET3,
        S_RAMWR_HI, S_RAMWR_LO,
        S_SKIP
    } dec_state_e;

endpackage

// File: rtl/m_spi_rx.sv
// SPI mode-2 byte deserializer: input synchronizers, SCL fall detect, shift register and idle timeout.
// ST7789_RX_STATS_EN adds the w_timeout pulse used by the error counter.
module m_spi_rx #(
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic       w_clk,
    input  logic       w_rst_n,
    input  logic       st7789_SDA,
    input  logic       st7789_SCL,
    input  logic       st7789_DC,
    input  logic       st7789_RES,
    output logic       w_res_act,
    output logic       w_rx_stb,
    output logic [8:0] w_rx_byte,
    output logic       w_byte_vld,
    output logic [8:0] w_byte
`ifdef ST7789_RX_STATS_EN
    ,
    output logic       w_timeout
`endif
);

    localparam int            IW        = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
    localparam logic [3:0]    SYNC_IDLE = 4'b1010; // {RES, DC, SCL, SDA} at rest

    logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
    logic          res_s, dc_s, scl_s, sda_s;
    logic          clr, fall, tmo;
    logic          scl_prev_q, scl_prev_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          dc_q, dc_d;
    logic          done_q, done_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          vld_q, vld_d;
    logic [8:0]    byte_q, byte_d;

    assign {res_s, dc_s, scl_s, sda_s} = sync_q[SYNC_STAGES-1];
    assign clr  = !w_rst_n || !res_s;
    assign fall = scl_prev_q && !scl_s;
    assign tmo  = scl_s && (bit_cnt_q != 3'd0) && (idle_q == IDLE_LAST);

    // NOTE: every signal gets its default first so no path can infer a latch.
    always_comb begin
        sync_d[0] = {st7789_RES, st7789_DC, st7789_SCL, st7789_SDA};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        scl_prev_d = scl_s;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        dc_d       = dc_q;
        done_d     = 1'b0;
        idle_d     = '0;
        vld_d      = done_q;
        byte_d     = done_q ? {dc_q, shift_q} : byte_q;
        if (fall) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                dc_d   = dc_s;
                done_d = 1'b1;
            end
        end else if (tmo) begin
            bit_cnt_d = 3'd0;
        end else if (scl_s && (bit_cnt_q != 3'd0)) begin
            idle_d = idle_q + IW'(1);
        end
    end

    always_ff @(posedge w_clk) begin
        // NOTE: synchronizers clear only on w_rst_n; clearing them from their own RES output would oscillate.
        if (!w_rst_n) begin
            sync_q <= {SYNC_STAGES{SYNC_IDLE}};
        end else begin
            sync_q <= sync_d;
        end
        if (clr) begin
            scl_prev_q <= 1'b1;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            dc_q       <= 1'b0;
            done_q     <= 1'b0;
            idle_q     <= '0;
            vld_q      <= 1'b0;
            byte_q     <= 9'd0;
        end else begin
            scl_prev_q <= scl_prev_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            dc_q       <= dc_d;
            done_q     <= done_d;
            idle_q     <= idle_d;
            vld_q      <= vld_d;
            byte_q     <= byte_d;
        end
    end

`ifdef ST7789_RX_STATS_EN
    logic timeout_q;

    always_ff @(posedge w_clk) begin
        if (clr) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= tmo;
        end
    end

    assign w_timeout = timeout_q;
`endif

    assign w_res_act  = !res_s;
    assign w_rx_stb   = done_q;
    assign w_rx_byte  = {dc_q, shift_q};
    assign w_byte_vld = vld_q;
    assign w_byte     = byte_q;

endmodule

// File: rtl/m_st7789_rx.sv
// ST7789 write-stream receiver: decodes CASET/RASET/RAMWR/DISPON into pixel writes for a shadow framebuffer.
// ST7789_RX_STATS_EN adds w_frame_cnt and w_err_cnt.
module m_st7789_rx
    import st7789_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 64,
    parameter int X_MAX        = 239,
    parameter int Y_MAX        = 239
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic        st7789_SDA,
    input  logic        st7789_SCL,
    input  logic        st7789_DC,
    input  logic        st7789_RES,
    output logic        w_byte_vld,
    output logic [8:0]  w_byte,
    output logic        w_we,
    output logic [15:0] w_wadr,
    output logic [15:0] w_wdata,
    output logic        w_disp_on
`ifdef ST7789_RX_STATS_EN
    ,
    output logic [15:0] w_frame_cnt,
    output logic [7:0]  w_err_cnt
`endif
);

    localparam logic [7:0] XE_RST = 8'(X_MAX);
    localparam logic [7:0] YE_RST = 8'(Y_MAX);

    logic       res_act, rx_stb, clr, is_cmd, is_dat;
    logic [8:0] rx_byte;
    logic [7:0] rx_val;

    dec_state_e  state_q, state_d;
    logic [7:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [7:0]  x_q, x_d, y_q, y_d, hi_q, hi_d, par_q, par_d;
    logic        disp_on_q, disp_on_d;
    logic        pend_we_q, pend_we_d;
    logic [15:0] pend_adr_q, pend_adr_d, pend_data_q, pend_data_d;
    logic        we_q, we_d;
    logic [15:0] wadr_q, wadr_d, wdata_q, wdata_d;

`ifdef ST7789_RX_STATS_EN
    logic        timeout, err_clr;
    logic [1:0]  err_inc;
    logic [8:0]  err_sum;
    logic [15:0] frame_q, frame_d;
    logic [7:0]  err_q, err_d;
`endif

    m_spi_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) u_spi_rx (
        .w_clk     (w_clk),
        .w_rst_n   (w_rst_n),
        .st7789_SDA(st7789_SDA),
        .st7789_SCL(st7789_SCL),
        .st7789_DC (st7789_DC),
        .st7789_RES(st7789_RES),
        .w_res_act (res_act),
        .w_rx_stb  (rx_stb),
        .w_rx_byte (rx_byte),
        .w_byte_vld(w_byte_vld),
        .w_byte    (w_byte)
`ifdef ST7789_RX_STATS_EN
        ,
        .w_timeout (timeout)
`endif
    );

    assign clr    = !w_rst_n || res_act;
    assign is_cmd = rx_stb && !rx_byte[8];
    assign is_dat = rx_stb && rx_byte[8];
    assign rx_val = rx_byte[7:0];

    // Decoding happens alongside w_byte_vld; the pixel strobe is staged one cycle behind it.
    always_comb begin
        state_d     = state_q;
        xs_d        = xs_q;
        xe_d        = xe_q;
        ys_d        = ys_q;
        ye_d        = ye_q;
        x_d         = x_q;
        y_d         = y_q;
        hi_d        = hi_q;
        par_d       = par_q;
        disp_on_d   = disp_on_q;
        pend_we_d   = 1'b0;
        pend_adr_d  = pend_adr_q;
        pend_data_d = pend_data_q;
        we_d        = pend_we_q;
        wadr_d      = pend_we_q ? pend_adr_q : wadr_q;
        wdata_d     = pend_we_q ? pend_data_q : wdata_q;
`ifdef ST7789_RX_STATS_EN
        frame_d = frame_q;
        err_clr = 1'b0;
        err_inc = {1'b0, timeout};
`endif
        if (is_cmd) begin
`ifdef ST7789_RX_STATS_EN
            if (state_q == S_RAMWR_LO) err_inc = err_inc + 2'd1;
`endif
            case (rx_val)
                CMD_CASET: state_d = S_CASET0;
                CMD_RASET: state_d = S_RASET0;
                CMD_RAMWR: begin
                    state_d = S_RAMWR_HI;
                    x_d     = xs_q;
                    y_d     = ys_q;
                end
                CMD_DISPON: begin
                    disp_on_d = 1'b1;
                    state_d   = S_IDLE;
                end
                CMD_DISPOFF: begin
                    disp_on_d = 1'b0;
                    state_d   = S_IDLE;
                end
                CMD_SWRESET: begin
                    xs_d      = 8'd0;
                    xe_d      = XE_RST;
                    ys_d      = 8'd0;
                    ye_d      = YE_RST;
                    disp_on_d = 1'b0;
                    state_d   = S_IDLE;
`ifdef ST7789_RX_STATS_EN
                    frame_d = 16'd0;
                    err_clr = 1'b1;
`endif
                end
                CMD_SLPOUT, CMD_NORON, CMD_INVON, CMD_MADCTL, CMD_COLMOD: state_d = S_SKIP;
                default: state_d = S_SKIP;
            endcase
        end else if (is_dat) begin
            case (state_q)
                S_CASET0: state_d = S_CASET1;
                S_CASET1: begin
                    par_d   = rx_val;
                    state_d = S_CASET2;
                end
                S_CASET2: state_d = S_CASET3;
                S_CASET3: begin
                    xs_d    = par_q;
                    xe_d    = rx_val;
                    state_d = S_IDLE;
                end
                S_RASET0: state_d = S_RASET1;
                S_RASET1: begin
                    par_d   = rx_val;
                    state_d = S_RASET2;
                end
                S_RASET2: state_d = S_RASET3;
                S_RASET3: begin
                    ys_d    = par_q;
                    ye_d    = rx_val;
                    state_d = S_IDLE;
                end
                S_RAMWR_HI: begin
                    hi_d    = rx_val;
                    state_d = S_RAMWR_LO;
                end
                S_RAMWR_LO: begin
                    pend_we_d   = 1'b1;
                    pend_adr_d  = {y_q, x_q};
                    pend_data_d = {hi_q, rx_val};
                    state_d     = S_RAMWR_HI;
                    if (x_q == xe_q) begin
                        x_d = xs_q;
                        y_d = (y_q == ye_q) ? ys_q : y_q + 8'd1;
                    end else begin
                        x_d = x_q + 8'd1;
                    end
`ifdef ST7789_RX_STATS_EN
                    if ((x_q == xe_q) && (y_q == ye_q)) frame_d = frame_q + 16'd1;
`endif
                end
                default: ;
            endcase
        end
`ifdef ST7789_RX_STATS_EN
        err_sum = {1'b0, err_q} + {7'd0, err_inc};
        if (err_clr) begin
            err_d = 8'd0;
        end else begin
            err_d = err_sum[8] ? 8'hFF : err_sum[7:0];
        end
`endif
    end

    always_ff @(posedge w_clk) begin
        if (clr) begin
            state_q     <= S_IDLE;
            xs_q        <= 8'd0;
            xe_q        <= XE_RST;
            ys_q        <= 8'd0;
            ye_q        <= YE_RST;
            x_q         <= 8'd0;
            y_q         <= 8'd0;
            hi_q        <= 8'd0;
            par_q       <= 8'd0;
            disp_on_q   <= 1'b0;
            pend_we_q   <= 1'b0;
            pend_adr_q  <= 16'd0;
            pend_data_q <= 16'd0;
            we_q        <= 1'b0;
            wadr_q      <= 16'd0;
            wdata_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            xs_q        <= xs_d;
            xe_q        <= xe_d;
            ys_q        <= ys_d;
            ye_q        <= ye_d;
            x_q         <= x_d;
            y_q         <= y_d;
            hi_q        <= hi_d;
            par_q       <= par_d;
            disp_on_q   <= disp_on_d;
            pend_we_q   <= pend_we_d;
            pend_adr_q  <= pend_adr_d;
            pend_data_q <= pend_data_d;
            we_q        <= we_d;
            wadr_q      <= wadr_d;
            wdata_q     <= wdata_d;
        end
    end

`ifdef ST7789_RX_STATS_EN
    always_ff @(posedge w_clk) begin
        if (clr) begin
            frame_q <= 16'd0;
            err_q   <= 8'd0;
        end else begin
            frame_q <= frame_d;
            err_q   <= err_d;
        end
    end

    assign w_frame_cnt = frame_q;
    assign w_err_cnt   = err_q;
`endif

    assign w_we      = we_q;
    assign w_wadr    = wadr_q;
    assign w_wdata   = wdata_q;
    assign w_disp_on = disp_on_q;

endmodule
